if_prefetch_stage: RTL and testbench
====================================

# if_prefetch_stage

Parametrised instruction-fetch stage with a prefetch queue: fetches sequential 32-bit instructions over a classic Wishbone master port into a FIFO_DEPTH-entry buffer and presents them to decode through a valid/ready handshake. Jump/branch and trap redirects flush the queue and restart fetching. Fetch exceptions (misaligned PC, bus error) travel with the instruction they belong to. Sits between the PC-control logic and the ID stage.

## Interface
- RESET_ADDR, 32'h8000_0000, fetch PC after reset
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- jb_valid_i  in  1  jump/branch redirect request
- jb_pc_i  in  32  jump/branch target
- trap_valid_i  in  1  trap redirect request; wins over jb_valid_i
- trap_pc_i  in  32  trap vector
- valid_o  out  1  head entry valid
- ready_i  in  1  decode accepts head entry
- instr_o  out  32  head instruction
- pc_o  out  32  head PC
- pc4_o  out  32  head PC+4
- is_trap_o  out  1  head entry carries a fetch exception
- trap_code_o  out  4  exception code
- wbm_addr_o  out  32  fetch address
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone cycle/strobe
- wbm_dat_i  in  32  read data
- wbm_ack_i, wbm_err_i  in  1  Wishbone ack/error

## Operation
- Fetch PC register fpc, reset to RESET_ADDR. Queue entry = {pc, instr, is_trap, trap_code}.
- FSM states: IDLE, REQ, DRAIN, HALT. Reset state is IDLE.
- IDLE: if a slot is free (count < FIFO_DEPTH), then:
  - fpc[1:0] ≠ 0: push {fpc, 0, 1, 4'd0 misaligned} with no bus cycle, go to HALT.
  - otherwise go to REQ.
- REQ: cyc = stb = 1, addr = fpc.
  - On ack: push {fpc, wbm_dat_i, 0, 0} and set fpc += 4. Stay in REQ if a slot remains after the push, counting a same-cycle pop; otherwise go to IDLE.
  - On err: push {fpc, 0, 1, 4'd1 access fault}, go to HALT. err takes priority over ack.
- HALT: no fetching until a redirect occurs.
- A redirect is trap_valid_i, or jb_valid_i when trap_valid_i is low. In the redirect cycle:
  - The queue is flushed: count becomes 0, and any same-cycle pop or push is discarded.
  - fpc is set to the target.
  - From REQ without ack/err: go to DRAIN.
  - From any other state, or REQ with ack/err this cycle: go to IDLE. The returned data or error is dropped.
- DRAIN: hold cyc/stb with the old address until ack or err, discard the response, then go to IDLE. A further redirect in DRAIN only updates fpc.
- Pop occurs when valid_o & ready_i. Push and pop in the same cycle keep count unchanged.
- Because a request is issued only while a slot is free and pops only free slots, an ack never arrives to a full queue.
- Head outputs are driven from queue storage. When the queue is empty, instr_o, pc_o, pc4_o, is_trap_o and trap_code_o are 0.
- Arithmetic is modulo 2^32: fpc+4 and pc+4 wrap 0xFFFF_FFFC to 0. Queue pointers have log2(FIFO_DEPTH) bits and wrap; count has log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (asynchronous assert, synchronous release) forces the following: state = IDLE, fpc = RESET_ADDR, count = 0, valid_o = 0, wbm_cyc_o = wbm_stb_o = 0, wbm_addr_o = RESET_ADDR, and all head outputs 0.
- Reset mid-transaction drops cyc/stb immediately; the slave response is ignored.
- First wbm_stb_o is asserted one cycle after the first clock edge with rst_ni high.
- Latency: ack in cycle N gives valid_o in cycle N+1.
- Throughput with a zero-wait slave and ready_i held high: one instruction per cycle, back-to-back strobes.
- Redirect in cycle N: valid_o = 0 in N+1.
  - New address on the bus in N+2 when the bus was idle.
  - When draining, new address on the bus two cycles after the draining ack/err.
- wbm_addr_o changes only in the cycle after an ack/err, or while cyc is low.

## Structure
- Package if_prefetch_pkg holds:
  - fetch_entry_t struct
  - fsm_state_t enum (IDLE, REQ, DRAIN, HALT)
  - TRAP_INSTR_MISALIGNED = 4'd0
  - TRAP_INSTR_ACCESS_FAULT = 4'd1
- One sub-module, if_fetch_fifo: a synchronous FIFO parametrised on depth and entry type, with push, pop, flush, count, full and empty.
- Flush has priority over push and pop inside the FIFO.

## Test plan
- Reset release, zero-wait slave returning addr^0xA5A5_A5A5, ready_i = 1 → stb asserted at 0x8000_0000, then PCs 0x8000_0000, 0x8000_0004, … on pc_o, one per cycle, with matching instr_o.
- ready_i = 0, FIFO_DEPTH = 4 → exactly 4 acks, then cyc drops and valid_o is held. Raising ready_i for one cycle leads to one new fetch.
- jb_valid_i with jb_pc_i = 0x8000_0100 while the slave stalls 3 cycles → cyc is held until the ack, no entry pushed, next stb at 0x8000_0100. trap_valid_i in the same cycle overrides the jb target.
- jb_pc_i = 0x8000_0102 → no bus cycle; one entry with is_trap_o = 1, trap_code_o = 0, pc_o = 0x8000_0102; then HALT until a redirect.
- wbm_err_i on fetch at 0x8000_0008 → entry with is_trap_o = 1, trap_code_o = 1, following the two good entries; no further strobes.
- rst_ni asserted mid-REQ → cyc/stb/valid_o go to 0 asynchronously; after release, fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package if_prefetch_pkg;

    // Exception codes carried alongside a fetched entry.
    localparam logic [3:0] TRAP_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0] TRAP_INSTR_ACCESS_FAULT = 4'd1;

    // One prefetch queue entry: the instruction plus where it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        is_trap;
        logic [3:0]  trap_code;
    } fetch_entry_t;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO with flush; depth must be a power of two so pointers wrap naturally.
module if_fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wdata,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush overrides any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; empty-gating downstream hides stale contents.
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: Wishbone fetch sequencer feeding a prefetch queue toward decode.
module if_prefetch_stage
    import if_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        jb_valid_i,
    input  logic [31:0] jb_pc_i,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        is_trap_o,
    output logic [3:0]  trap_code_o,
    output logic [31:0] wbm_addr_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fsm_state_t   state, state_next;
    logic [31:0]  fpc, fpc_next;
    logic [31:0]  drain_addr;
    logic         redirect;
    logic [31:0]  target;
    logic         pop;
    logic         push;
    fetch_entry_t push_entry;
    fetch_entry_t fifo_head;
    fetch_entry_t head;
    logic [CW-1:0] fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         bus_resp;
    logic         slot_left;

    // Trap redirect wins over jump/branch.
    assign redirect  = trap_valid_i || jb_valid_i;
    assign target    = trap_valid_i ? trap_pc_i : jb_pc_i;
    assign pop       = valid_o && ready_i;
    assign bus_resp  = wbm_ack_i || wbm_err_i;
    // A slot remains after this push if count + 1 - pop < FIFO_DEPTH.
    assign slot_left = (fifo_count < CW'(FIFO_DEPTH - 1)) || pop;

    // Next-state, next fetch PC and queue push selection.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        fpc_next   = fpc;
        push       = 1'b0;
        push_entry = '0;
        case (state)
            IDLE: begin
                if (!fifo_full) begin
                    if (fpc[1:0] != 2'b00) begin
                        push       = 1'b1;
                        push_entry = '{pc: fpc, instr: 32'd0, is_trap: 1'b1,
                                       trap_code: TRAP_INSTR_MISALIGNED};
                        state_next = HALT;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (wbm_err_i) begin
                    push       = 1'b1;
                    push_entry = '{pc: fpc, instr: 32'd0, is_trap: 1'b1,
                                   trap_code: TRAP_INSTR_ACCESS_FAULT};
                    state_next = HALT;
                end else if (wbm_ack_i) begin
                    push       = 1'b1;
                    push_entry = '{pc: fpc, instr: wbm_dat_i, is_trap: 1'b0, trap_code: 4'd0};
                    fpc_next   = fpc + 32'd4;
                    state_next = slot_left ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (bus_resp) state_next = IDLE;
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = IDLE;
        endcase

        // Redirect: the queue flush drops any push; an open bus cycle must still be drained.
        if (redirect) begin
            fpc_next = target;
            if (state == REQ && !bus_resp) begin
                state_next = DRAIN;
            end else if (state != DRAIN) begin
                state_next = IDLE;
            end
        end
    end

    // Sequencer state and fetch PC registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            fpc   <= RESET_ADDR;
        end else begin
            state <= state_next;
            fpc   <= fpc_next;
        end
    end

    // Remember the abandoned request address so the bus stays stable while draining.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain_addr <= RESET_ADDR;
        end else if (state == REQ && redirect && !bus_resp) begin
            drain_addr <= fpc;
        end
    end

    if_fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wbm_cyc_o  = (state == REQ) || (state == DRAIN);
    assign wbm_stb_o  = wbm_cyc_o;
    assign wbm_addr_o = (state == DRAIN) ? drain_addr : fpc;

    // Head outputs read zero whenever the queue is empty.
    assign valid_o     = !fifo_empty;
    assign head        = fifo_empty ? '0 : fifo_head;
    assign instr_o     = head.instr;
    assign pc_o        = head.pc;
    assign pc4_o       = fifo_empty ? 32'd0 : head.pc + 32'd4;
    assign is_trap_o   = head.is_trap;
    assign trap_code_o = head.trap_code;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with a behavioural Wishbone slave.
module tb_if_prefetch_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] XMASK  = 32'hA5A5_A5A5;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        jb_valid_i = 1'b0;
    logic [31:0] jb_pc_i = '0;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_pc_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o, pc_o, pc4_o;
    logic        is_trap_o;
    logic [3:0]  trap_code_o;
    logic [31:0] wbm_addr_o;
    logic        wbm_cyc_o, wbm_stb_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;

    int          n_vec = 0;
    int          n_err = 0;

    // Slave configuration (written only by the stimulus process).
    int          wait_cycles = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    // Slave state (written only by the slave processes).
    int          stall_cnt = 0;
    int          ack_total = 0;
    logic        hit;

    always #5 clk_i = ~clk_i;

    if_prefetch_stage dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .jb_valid_i   (jb_valid_i),
        .jb_pc_i      (jb_pc_i),
        .trap_valid_i (trap_valid_i),
        .trap_pc_i    (trap_pc_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc4_o        (pc4_o),
        .is_trap_o    (is_trap_o),
        .trap_code_o  (trap_code_o),
        .wbm_addr_o   (wbm_addr_o),
        .wbm_cyc_o    (wbm_cyc_o),
        .wbm_stb_o    (wbm_stb_o),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_ack_i    (wbm_ack_i),
        .wbm_err_i    (wbm_err_i)
    );

    // Slave: respond after wait_cycles stall cycles; data is address ^ XMASK.
    assign hit       = wbm_cyc_o && wbm_stb_o && (stall_cnt >= wait_cycles);
    assign wbm_err_i = hit && err_en && (wbm_addr_o == err_addr);
    assign wbm_ack_i = hit && !wbm_err_i;
    assign wbm_dat_i = wbm_addr_o ^ XMASK;

    always @(posedge clk_i) begin
        if (!(wbm_cyc_o && wbm_stb_o) || wbm_ack_i || wbm_err_i) stall_cnt <= 0;
        else stall_cnt <= stall_cnt + 1;
    end

    always @(posedge clk_i) begin
        if (wbm_ack_i) ack_total <= ack_total + 1;
    end

    typedef struct {
        logic        ready;
        logic        valid;
        logic [31:0] pc;
        logic        cyc;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Check the full head record against an expected entry.
    task automatic check_head(input string name, input logic v, input logic [31:0] pc,
                              input logic [31:0] instr, input logic tr, input logic [3:0] code);
        check({name, "_valid"}, 32'(valid_o), 32'(v));
        check({name, "_pc"}, pc_o, v ? pc : 32'd0);
        check({name, "_pc4"}, pc4_o, v ? pc + 32'd4 : 32'd0);
        check({name, "_instr"}, instr_o, v ? instr : 32'd0);
        check({name, "_trap"}, 32'(is_trap_o), 32'(v && tr));
        check({name, "_code"}, 32'(trap_code_o), v ? 32'(code) : 32'd0);
    endtask

    task automatic check_bus(input string name, input logic cyc, input logic [31:0] addr);
        check({name, "_cyc"}, 32'(wbm_cyc_o), 32'(cyc));
        check({name, "_stb"}, 32'(wbm_stb_o), 32'(cyc));
        check({name, "_addr"}, wbm_addr_o, addr);
    endtask

    // Leaves the bench just after a negedge with rst_ni released (cycle 0).
    task automatic do_reset();
        rst_ni       = 1'b0;
        jb_valid_i   = 1'b0;
        trap_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Redirect during a 3-cycle stall; trap_en also raises trap_valid_i with a different target.
    task automatic drain_seq(input string name, input logic trap_en, input logic [31:0] exp_pc);
        wait_cycles = 3;
        ready_i     = 1'b1;
        do_reset();
        next_cycle();
        jb_valid_i   = 1'b1;
        jb_pc_i      = 32'h8000_0100;
        trap_valid_i = trap_en;
        trap_pc_i    = 32'h8000_0200;
        next_cycle();
        jb_valid_i   = 1'b0;
        trap_valid_i = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk_i);
            if (c <= 4) begin
                check_bus({name, "_hold"}, 1'b1, RST_PC);
                check({name, "_hold_valid"}, 32'(valid_o), 32'd0);
            end else if (c == 5) begin
                check_bus({name, "_idle"}, 1'b0, exp_pc);
                check({name, "_idle_valid"}, 32'(valid_o), 32'd0);
            end else if (c == 6) begin
                check_bus({name, "_newreq"}, 1'b1, exp_pc);
            end else if (c == 10) begin
                check_head({name, "_first"}, 1'b1, exp_pc, exp_pc ^ XMASK, 1'b0, 4'd0);
            end
            if (c < 10) next_cycle();
        end
        wait_cycles = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        //             ready  valid  pc             cyc   addr
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h8000_0000};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0004};
        vecs[2] = '{1'b0, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0008};
        vecs[3] = '{1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_000C};
        vecs[4] = '{1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0010};
        vecs[5] = '{1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0014};
        vecs[6] = '{1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0018};

        // Reset state, then streaming with a zero-wait slave and one decode stall.
        ready_i = 1'b1;
        do_reset();
        check_bus("rst", 1'b0, RST_PC);
        check_head("rst", 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            ready_i = vecs[i].ready;
            @(negedge clk_i);
            check_bus($sformatf("vec%0d", i), vecs[i].cyc, vecs[i].addr);
            check_head($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc,
                       vecs[i].pc ^ XMASK, 1'b0, 4'd0);
        end

        // Decode stalled: the queue fills with exactly FIFO_DEPTH fetches.
        ready_i = 1'b0;
        base    = ack_total;
        do_reset();
        repeat (20) next_cycle();
        @(negedge clk_i);
        check("full_acks", 32'(ack_total - base), 32'd4);
        check_bus("full", 1'b0, 32'h8000_0010);
        check_head("full", 1'b1, RST_PC, RST_PC ^ XMASK, 1'b0, 4'd0);
        next_cycle();
        ready_i = 1'b1;
        next_cycle();
        ready_i = 1'b0;
        repeat (10) next_cycle();
        @(negedge clk_i);
        check("refill_acks", 32'(ack_total - base), 32'd5);
        check_bus("refill", 1'b0, 32'h8000_0014);
        check_head("refill", 1'b1, 32'h8000_0004, 32'h8000_0004 ^ XMASK, 1'b0, 4'd0);

        // Redirect while the slave stalls, jump only and with an overriding trap.
        drain_seq("jb_drain", 1'b0, 32'h8000_0100);
        drain_seq("trap_drain", 1'b1, 32'h8000_0200);

        // Misaligned target: trap entry without a bus cycle, then halt until redirected.
        ready_i = 1'b0;
        do_reset();
        next_cycle();
        jb_valid_i = 1'b1;
        jb_pc_i    = 32'h8000_0102;
        next_cycle();
        jb_valid_i = 1'b0;
        @(negedge clk_i);
        check_bus("mis_idle", 1'b0, 32'h8000_0102);
        check("mis_idle_valid", 32'(valid_o), 32'd0);
        base = ack_total;
        next_cycle();
        @(negedge clk_i);
        check_bus("mis_entry", 1'b0, 32'h8000_0102);
        check_head("mis_entry", 1'b1, 32'h8000_0102, 32'd0, 1'b1, 4'd0);
        repeat (5) next_cycle();
        ready_i = 1'b1;
        next_cycle();
        ready_i = 1'b0;
        @(negedge clk_i);
        check("mis_halt_acks", 32'(ack_total - base), 32'd0);
        check_bus("mis_halt", 1'b0, 32'h8000_0102);
        check("mis_halt_valid", 32'(valid_o), 32'd0);
        next_cycle();
        jb_valid_i = 1'b1;
        jb_pc_i    = RST_PC;
        next_cycle();
        jb_valid_i = 1'b0;
        next_cycle();
        @(negedge clk_i);
        check_bus("mis_resume", 1'b1, RST_PC);

        // Bus error on the third fetch: trap entry follows the two good ones.
        ready_i  = 1'b0;
        err_en   = 1'b1;
        err_addr = 32'h8000_0008;
        do_reset();
        base = ack_total;
        repeat (4) next_cycle();
        ready_i = 1'b1;
        @(negedge clk_i);
        check_bus("err_c4", 1'b0, 32'h8000_0008);
        check_head("err_c4", 1'b1, RST_PC, RST_PC ^ XMASK, 1'b0, 4'd0);
        next_cycle();
        @(negedge clk_i);
        check_head("err_c5", 1'b1, 32'h8000_0004, 32'h8000_0004 ^ XMASK, 1'b0, 4'd0);
        next_cycle();
        @(negedge clk_i);
        check_head("err_c6", 1'b1, 32'h8000_0008, 32'd0, 1'b1, 4'd1);
        next_cycle();
        @(negedge clk_i);
        check_head("err_c7", 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        check("err_acks", 32'(ack_total - base), 32'd2);
        check("err_cyc", 32'(wbm_cyc_o), 32'd0);
        err_en = 1'b0;

        // Asynchronous reset in the middle of a request.
        ready_i = 1'b0;
        do_reset();
        repeat (3) next_cycle();
        #2;
        rst_ni = 1'b0;
        #1;
        check_bus("async_rst", 1'b0, RST_PC);
        check_head("async_rst", 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();
        @(negedge clk_i);
        check_bus("restart", 1'b1, RST_PC);
        next_cycle();
        @(negedge clk_i);
        check_head("restart", 1'b1, RST_PC, RST_PC ^ XMASK, 1'b0, 4'd0);

        // Address wrap: fetch at 0xFFFF_FFFC continues at 0.
        ready_i = 1'b1;
        do_reset();
        next_cycle();
        jb_valid_i = 1'b1;
        jb_pc_i    = 32'hFFFF_FFFC;
        next_cycle();
        jb_valid_i = 1'b0;
        next_cycle();
        @(negedge clk_i);
        check_bus("wrap_req", 1'b1, 32'hFFFF_FFFC);
        next_cycle();
        @(negedge clk_i);
        check_bus("wrap_next", 1'b1, 32'h0000_0000);
        check_head("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A59, 1'b0, 4'd0);
        next_cycle();
        @(negedge clk_i);
        check_head("wrap_zero", 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
